// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle MIPS datapath (IR, A/B/ALUOut, shared memory).
// Latency: lw 5, sw/R/addi/slti 4, beq/j 3 cycles; stalls in FETCH/MEM_READ/MEM_WRITE until mem_ready.
module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   iord,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   mem_to_reg,
  output logic                   reg_dst,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic [1:0]             pc_source,
  output logic                   illegal_op,
  output logic                   retire,
  output logic [3:0]             state,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  state_t cur;
  // lw/sw choice is captured in DECODE so MEM_ADDR ignores later opcode changes
  logic   is_store;
  logic   op_legal;

  assign state = cur;

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_R, OP_J, OP_BEQ, OP_ADDI, OP_SLTI, OP_LW, OP_SW: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur         <= S_IDLE;
      is_store    <= 1'b0;
      instr_count <= '0;
    end else begin
      if (retire) instr_count <= instr_count + COUNT_WIDTH'(1);
      case (cur)
        S_IDLE:      cur <= S_FETCH;
        S_FETCH:     if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
          is_store <= (opcode == OP_SW);
          case (opcode)
            OP_LW, OP_SW:     cur <= S_MEM_ADDR;
            OP_R:             cur <= S_R_EXEC;
            OP_ADDI, OP_SLTI: cur <= S_I_EXEC;
            OP_BEQ:           cur <= S_BRANCH;
            OP_J:             cur <= S_JUMP;
            default:          cur <= S_FETCH;
          endcase
        end
        S_MEM_ADDR:  cur <= is_store ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (mem_ready) cur <= S_MEM_WB;
        S_MEM_WRITE: if (mem_ready) cur <= S_FETCH;
        S_R_EXEC:    cur <= S_R_WB;
        S_I_EXEC:    cur <= S_I_WB;
        default:     cur <= S_FETCH;
      endcase
    end
  end

  // Outputs decode straight from the state register so reset clears them at once.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    retire        = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        alu_op     = 2'b11;
        illegal_op = !op_legal;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
      end
      S_R_EXEC: alu_src_a = 1'b1;
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OP_SLTI) ? 2'b10 : 2'b11;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus reset and counter-wrap sequences.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic        mem_ready = 1'b1;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, retire;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] instr_count;

  // Narrow-counter instance runs only R-type instructions.
  logic        reset2 = 1'b1;
  logic        pw2, pwc2, iord2, mr2, mw2, irw2, m2r2, rd2, rw2, asa2, ill2, ret2;
  logic [1:0]  asb2, aop2, psrc2;
  logic [3:0]  state2;
  logic [3:0]  count2;

  always #5 clk = ~clk;

  multicycle_control #(.COUNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .retire(retire),
    .state(state), .instr_count(instr_count)
  );

  multicycle_control #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset2), .opcode(6'd0), .mem_ready(1'b1),
    .pc_write(pw2), .pc_write_cond(pwc2), .iord(iord2),
    .mem_read(mr2), .mem_write(mw2), .ir_write(irw2),
    .mem_to_reg(m2r2), .reg_dst(rd2), .reg_write(rw2),
    .alu_src_a(asa2), .alu_src_b(asb2), .alu_op(aop2),
    .pc_source(psrc2), .illegal_op(ill2), .retire(ret2),
    .state(state2), .instr_count(count2)
  );

  // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
  //  reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, retire}
  logic [17:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, retire};

  localparam logic [17:0] C_IDLE = 18'b0000000000_00_00_00_00;
  localparam logic [17:0] C_FR   = 18'b1001010000_01_11_00_00;
  localparam logic [17:0] C_FW   = 18'b0001000000_01_11_00_00;
  localparam logic [17:0] C_DEC  = 18'b0000000000_11_11_00_00;
  localparam logic [17:0] C_DILL = 18'b0000000000_11_11_00_10;
  localparam logic [17:0] C_MA   = 18'b0000000001_10_11_00_00;
  localparam logic [17:0] C_MRD  = 18'b0011000000_00_00_00_00;
  localparam logic [17:0] C_MWB  = 18'b0000001010_00_00_00_01;
  localparam logic [17:0] C_MWR  = 18'b0010100000_00_00_00_01;
  localparam logic [17:0] C_MWW  = 18'b0010100000_00_00_00_00;
  localparam logic [17:0] C_REX  = 18'b0000000001_00_00_00_00;
  localparam logic [17:0] C_RWB  = 18'b0000000110_00_00_00_01;
  localparam logic [17:0] C_IADD = 18'b0000000001_10_11_00_00;
  localparam logic [17:0] C_ISLT = 18'b0000000001_10_10_00_00;
  localparam logic [17:0] C_IWB  = 18'b0000000010_00_00_00_01;
  localparam logic [17:0] C_BR   = 18'b0100000001_00_01_01_01;
  localparam logic [17:0] C_J    = 18'b1000000000_00_00_10_01;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] ctl;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                     input logic [17:0] ctl, input logic [31:0] cnt);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    // Main program with mem_ready high; FETCH opcode values are junk on purpose.
    add(6'd0,  1, 4'd0,  C_IDLE, 0);
    add(6'h3F, 1, 4'd1,  C_FR,   0);  // lw
    add(6'd35, 1, 4'd2,  C_DEC,  0);
    add(6'd43, 1, 4'd3,  C_MA,   0);
    add(6'd0,  1, 4'd4,  C_MRD,  0);
    add(6'd0,  1, 4'd5,  C_MWB,  0);
    add(6'd0,  1, 4'd1,  C_FR,   1);  // sw
    add(6'd43, 1, 4'd2,  C_DEC,  1);
    add(6'd43, 1, 4'd3,  C_MA,   1);
    add(6'd43, 1, 4'd6,  C_MWR,  1);
    add(6'd0,  1, 4'd1,  C_FR,   2);  // add
    add(6'd0,  1, 4'd2,  C_DEC,  2);
    add(6'd0,  1, 4'd7,  C_REX,  2);
    add(6'd0,  1, 4'd8,  C_RWB,  2);
    add(6'd8,  1, 4'd1,  C_FR,   3);  // addi
    add(6'd8,  1, 4'd2,  C_DEC,  3);
    add(6'd8,  1, 4'd9,  C_IADD, 3);
    add(6'd8,  1, 4'd10, C_IWB,  3);
    add(6'd10, 1, 4'd1,  C_FR,   4);  // slti
    add(6'd10, 1, 4'd2,  C_DEC,  4);
    add(6'd10, 1, 4'd9,  C_ISLT, 4);
    add(6'd10, 1, 4'd10, C_IWB,  4);
    add(6'd4,  1, 4'd1,  C_FR,   5);  // beq
    add(6'd4,  1, 4'd2,  C_DEC,  5);
    add(6'd4,  1, 4'd11, C_BR,   5);
    add(6'd2,  1, 4'd1,  C_FR,   6);  // j
    add(6'd2,  1, 4'd2,  C_DEC,  6);
    add(6'd2,  1, 4'd12, C_J,    6);
    // lw with 3 FETCH stalls and 2 MEM_READ stalls: 10 cycles
    add(6'd35, 0, 4'd1,  C_FW,   7);
    add(6'd35, 0, 4'd1,  C_FW,   7);
    add(6'd35, 0, 4'd1,  C_FW,   7);
    add(6'd35, 1, 4'd1,  C_FR,   7);
    add(6'd35, 0, 4'd2,  C_DEC,  7);
    add(6'd35, 0, 4'd3,  C_MA,   7);
    add(6'd35, 0, 4'd4,  C_MRD,  7);
    add(6'd35, 0, 4'd4,  C_MRD,  7);
    add(6'd35, 1, 4'd4,  C_MRD,  7);
    add(6'd35, 0, 4'd5,  C_MWB,  7);
    // illegal opcode
    add(6'h3F, 1, 4'd1,  C_FR,   8);
    add(6'h3F, 1, 4'd2,  C_DILL, 8);
    add(6'd43, 1, 4'd1,  C_FR,   8);  // sw, then stall in MEM_WRITE for reset test
    add(6'd43, 1, 4'd2,  C_DEC,  8);
    add(6'd43, 1, 4'd3,  C_MA,   8);
    add(6'd43, 0, 4'd6,  C_MWW,  8);
    add(6'd43, 0, 4'd6,  C_MWW,  8);

    // reset state
    #2;
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctrl", 32'(ctrl), 32'(C_IDLE));
    check("reset_count", instr_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      opcode    = vecs[i].op;
      mem_ready = vecs[i].rdy;
      #1;
      check($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("v%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].ctl));
      check($sformatf("v%0d_count", i), instr_count, vecs[i].cnt);
    end

    // async reset mid-MEM_WRITE
    #1;
    reset = 1'b1;
    #1;
    check("arst_mem_write", 32'(mem_write), 32'd0);
    check("arst_state", 32'(state), 32'd0);
    check("arst_count", instr_count, 32'd0);
    check("arst_ctrl", 32'(ctrl), 32'(C_IDLE));
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rel_idle", 32'(state), 32'd0);
    @(negedge clk);
    #1;
    check("rel_fetch_state", 32'(state), 32'd1);
    check("rel_fetch_read", 32'(mem_read), 32'd1);

    // 4-bit counter wrap with back-to-back R-type
    @(negedge clk);
    reset2 = 1'b0;
    repeat (65) @(posedge clk);
    #1;
    check("wrap16_count", 32'(count2), 32'd0);
    check("wrap16_state", 32'(state2), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("wrap17_count", 32'(count2), 32'd1);
    check("wrap17_state", 32'(state2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
